// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-block RTL: bus status codes, bridge FSM states
// and AXI response width.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } rggen_axi4lite_bridge_state;

    localparam int RGGEN_AXI_RESP_WIDTH = 2;

endpackage

// File: rtl/rggen_bus_if.sv
// Single-request bus between the protocol bridge (master) and the register
// adapter (slave).
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                       valid;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic                       write;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       ready;
    rggen_status                status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport master (
        output valid, address, write, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, address, write, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_request_holder.sv
// One-deep valid/ready capture register; ready is simply !full, and the owner
// frees the slot with i_clear once the request has been consumed.
module rggen_request_holder #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Capture and clear never coincide: capture needs empty, clear needs full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (i_valid && !full_q) begin
            full_d = 1'b1;
            data_d = i_data;
        end else if (i_clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign o_ready = !full_q;
    assign o_full  = full_q;
    assign o_data  = data_q;
endmodule

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave front end: buffers AW/W/AR, serialises them onto rggen_bus_if
// one at a time and returns the captured status/data on B or R.
//
// state | meaning
// IDLE  | waiting for a complete write (AW+W) or a read (AR); arbitrate
// BUS   | request driven on bus_if, held until bus_if.ready
// RESP  | B or R response presented, held until bready/rready
module rggen_axi4lite_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter bit WRITE_FIRST   = 1'b1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_awvalid,
    output logic                            o_awready,
    input  logic [ADDRESS_WIDTH-1:0]        i_awaddr,
    input  logic                            i_wvalid,
    output logic                            o_wready,
    input  logic [BUS_WIDTH-1:0]            i_wdata,
    input  logic [BUS_WIDTH/8-1:0]          i_wstrb,
    output logic                            o_bvalid,
    input  logic                            i_bready,
    output logic [RGGEN_AXI_RESP_WIDTH-1:0] o_bresp,
    input  logic                            i_arvalid,
    output logic                            o_arready,
    input  logic [ADDRESS_WIDTH-1:0]        i_araddr,
    output logic                            o_rvalid,
    input  logic                            i_rready,
    output logic [BUS_WIDTH-1:0]            o_rdata,
    output logic [RGGEN_AXI_RESP_WIDTH-1:0] o_rresp,
    rggen_bus_if.master                     bus_if
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    rggen_axi4lite_bridge_state      state_q, state_d;
    logic                            grant_write_q, grant_write_d;
    logic [RGGEN_AXI_RESP_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_WIDTH-1:0]            rdata_q, rdata_d;

    logic                            aw_full, w_full, ar_full;
    logic [ADDRESS_WIDTH-1:0]        aw_addr, ar_addr;
    logic [BUS_WIDTH-1:0]            w_data;
    logic [STRB_WIDTH-1:0]           w_strb;
    logic                            bus_done;
    logic                            write_pending, read_pending;

    rggen_request_holder #(.WIDTH(ADDRESS_WIDTH)) u_aw (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_awvalid), .o_ready(o_awready), .i_data(i_awaddr),
        .i_clear(bus_done && grant_write_q), .o_full(aw_full), .o_data(aw_addr)
    );

    rggen_request_holder #(.WIDTH(BUS_WIDTH + STRB_WIDTH)) u_w (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_wvalid), .o_ready(o_wready), .i_data({i_wstrb, i_wdata}),
        .i_clear(bus_done && grant_write_q), .o_full(w_full), .o_data({w_strb, w_data})
    );

    rggen_request_holder #(.WIDTH(ADDRESS_WIDTH)) u_ar (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_arvalid), .o_ready(o_arready), .i_data(i_araddr),
        .i_clear(bus_done && !grant_write_q), .o_full(ar_full), .o_data(ar_addr)
    );

    assign write_pending = aw_full && w_full;
    assign read_pending  = ar_full;

    always_comb begin
        state_d       = state_q;
        grant_write_d = grant_write_q;
        resp_d        = resp_q;
        rdata_d       = rdata_q;
        bus_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_pending && (WRITE_FIRST || !read_pending)) begin
                    grant_write_d = 1'b1;
                    state_d       = BUS;
                end else if (read_pending) begin
                    grant_write_d = 1'b0;
                    state_d       = BUS;
                end
            end
            BUS: begin
                if (bus_if.ready) begin
                    resp_d   = bus_if.status;
                    bus_done = 1'b1;
                    state_d  = RESP;
                    if (!grant_write_q) begin
                        rdata_d = bus_if.read_data;
                    end
                end
            end
            RESP: begin
                if (grant_write_q ? i_bready : i_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            grant_write_q <= 1'b0;
            resp_q        <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_write_q <= grant_write_d;
            resp_q        <= resp_d;
            rdata_q       <= rdata_d;
        end
    end

    // Reads present all-ones strobe and zero data so the adapter sees a clean request.
    assign bus_if.valid      = (state_q == BUS);
    assign bus_if.address    = grant_write_q ? aw_addr : ar_addr;
    assign bus_if.write      = grant_write_q;
    assign bus_if.write_data = grant_write_q ? w_data : '0;
    assign bus_if.strobe     = grant_write_q ? w_strb : '1;

    assign o_bvalid = (state_q == RESP) && grant_write_q;
    assign o_rvalid = (state_q == RESP) && !grant_write_q;
    assign o_bresp  = resp_q;
    assign o_rresp  = resp_q;
    assign o_rdata  = rdata_q;
endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed bench for rggen_axi4lite_bridge; two instances differ only in
// WRITE_FIRST and share all stimulus.
module tb_rggen_axi4lite_bridge;
    import rggen_rtl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [15:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bus_ready = 1'b0;
    logic [1:0]  bus_status = 2'b00;
    logic [31:0] bus_rdata = '0;

    logic [1:0]  awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [31:0] rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bif0 ();
    rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bif1 ();

    assign bif0.ready     = bus_ready;
    assign bif0.status    = rggen_status'(bus_status);
    assign bif0.read_data = bus_rdata;
    assign bif1.ready     = bus_ready;
    assign bif1.status    = rggen_status'(bus_status);
    assign bif1.read_data = bus_rdata;

    rggen_axi4lite_bridge #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32), .WRITE_FIRST(1'b1)) u_wf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_awvalid(awvalid), .o_awready(awready[0]), .i_awaddr(awaddr),
        .i_wvalid(wvalid), .o_wready(wready[0]), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_bvalid(bvalid[0]), .i_bready(bready), .o_bresp(bresp[0]),
        .i_arvalid(arvalid), .o_arready(arready[0]), .i_araddr(araddr),
        .o_rvalid(rvalid[0]), .i_rready(rready), .o_rdata(rdata[0]), .o_rresp(rresp[0]),
        .bus_if(bif0.master)
    );

    rggen_axi4lite_bridge #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32), .WRITE_FIRST(1'b0)) u_rf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_awvalid(awvalid), .o_awready(awready[1]), .i_awaddr(awaddr),
        .i_wvalid(wvalid), .o_wready(wready[1]), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_bvalid(bvalid[1]), .i_bready(bready), .o_bresp(bresp[1]),
        .i_arvalid(arvalid), .o_arready(arready[1]), .i_araddr(araddr),
        .o_rvalid(rvalid[1]), .i_rready(rready), .o_rdata(rdata[1]), .o_rresp(rresp[1]),
        .bus_if(bif1.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_awready", 64'(awready[0]), 64'd1);
        chk("rst_wready", 64'(wready[0]), 64'd1);
        chk("rst_arready", 64'(arready[0]), 64'd1);
        chk("rst_bvalid", 64'(bvalid[0]), 64'd0);
        chk("rst_rvalid", 64'(rvalid[0]), 64'd0);
        chk("rst_bresp", 64'(bresp[0]), 64'd0);
        chk("rst_rresp", 64'(rresp[0]), 64'd0);
        chk("rst_rdata", 64'(rdata[0]), 64'd0);
        chk("rst_bus_valid", 64'(bif0.valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // single write, AW and W together, bus ready immediately
        bus_ready = 1'b1; bus_status = 2'b00;
        awvalid = 1'b1; awaddr = 16'h0010;
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();                                   // handshake edge; now T+1
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr1_awready_full", 64'(awready[0]), 64'd0);
        chk("wr1_wready_full", 64'(wready[0]), 64'd0);
        chk("wr1_valid_t1", 64'(bif0.valid), 64'd0);
        tick();                                   // T+2
        chk("wr1_valid_t2", 64'(bif0.valid), 64'd1);
        chk("wr1_addr", 64'(bif0.address), 64'h0010);
        chk("wr1_write", 64'(bif0.write), 64'd1);
        chk("wr1_strobe", 64'(bif0.strobe), 64'hF);
        chk("wr1_wdata", 64'(bif0.write_data), 64'hDEADBEEF);
        tick();                                   // T+3
        chk("wr1_bvalid_t3", 64'(bvalid[0]), 64'd1);
        chk("wr1_bresp", 64'(bresp[0]), 64'd0);
        chk("wr1_valid_t3", 64'(bif0.valid), 64'd0);
        chk("wr1_awready_free", 64'(awready[0]), 64'd1);
        tick();                                   // T+4
        chk("wr1_bvalid_t4", 64'(bvalid[0]), 64'd0);
        chk("wr1_rvalid_t4", 64'(rvalid[0]), 64'd0);

        // W two cycles before AW, three bus wait states
        bus_ready = 1'b0;
        wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'h3;
        tick();
        wvalid = 1'b0;
        chk("wr2_wready_full", 64'(wready[0]), 64'd0);
        chk("wr2_awready_empty", 64'(awready[0]), 64'd1);
        tick();
        chk("wr2_no_early_valid", 64'(bif0.valid), 64'd0);
        awvalid = 1'b1; awaddr = 16'h0024;
        tick();
        awvalid = 1'b0;
        chk("wr2_valid_pre", 64'(bif0.valid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_ready = 1'b1;
            chk($sformatf("wr2_valid_%0d", i), 64'(bif0.valid), 64'd1);
            chk($sformatf("wr2_addr_%0d", i), 64'(bif0.address), 64'h0024);
            chk($sformatf("wr2_wdata_%0d", i), 64'(bif0.write_data), 64'hCAFEF00D);
            chk($sformatf("wr2_strobe_%0d", i), 64'(bif0.strobe), 64'h3);
            chk($sformatf("wr2_bvalid_%0d", i), 64'(bvalid[0]), 64'd0);
            tick();
        end
        bus_ready = 1'b0;
        chk("wr2_valid_end", 64'(bif0.valid), 64'd0);
        chk("wr2_bvalid", 64'(bvalid[0]), 64'd1);
        chk("wr2_bresp", 64'(bresp[0]), 64'd0);
        tick();
        chk("wr2_bvalid_done", 64'(bvalid[0]), 64'd0);

        // read with SLAVE_ERROR, R held under rready=0
        bus_ready = 1'b1; bus_status = 2'b10; bus_rdata = 32'h12345678;
        rready = 1'b0;
        arvalid = 1'b1; araddr = 16'h0030;
        tick();
        arvalid = 1'b0;
        chk("rd_arready_full", 64'(arready[0]), 64'd0);
        tick();
        chk("rd_valid", 64'(bif0.valid), 64'd1);
        chk("rd_write", 64'(bif0.write), 64'd0);
        chk("rd_addr", 64'(bif0.address), 64'h0030);
        chk("rd_wdata", 64'(bif0.write_data), 64'h0);
        chk("rd_strobe", 64'(bif0.strobe), 64'hF);
        tick();
        bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rd_rvalid_%0d", i), 64'(rvalid[0]), 64'd1);
            chk($sformatf("rd_rresp_%0d", i), 64'(rresp[0]), 64'h2);
            chk($sformatf("rd_rdata_%0d", i), 64'(rdata[0]), 64'h12345678);
            tick();
        end
        chk("rd_arready_free", 64'(arready[0]), 64'd1);
        rready = 1'b1;
        tick();
        chk("rd_rvalid_done", 64'(rvalid[0]), 64'd0);

        // simultaneous write and read: u_wf writes first, u_rf reads first
        bus_ready = 1'b1; bus_status = 2'b00; bus_rdata = 32'hA5A5A5A5;
        awvalid = 1'b1; awaddr = 16'h0040;
        wvalid = 1'b1; wdata = 32'h11112222; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 16'h0044;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        chk("arb_wf_first_write", 64'(bif0.write), 64'd1);
        chk("arb_wf_first_addr", 64'(bif0.address), 64'h0040);
        chk("arb_rf_first_write", 64'(bif1.write), 64'd0);
        chk("arb_rf_first_addr", 64'(bif1.address), 64'h0044);
        tick();
        chk("arb_wf_bvalid", 64'(bvalid[0]), 64'd1);
        chk("arb_wf_rvalid", 64'(rvalid[0]), 64'd0);
        chk("arb_rf_rvalid", 64'(rvalid[1]), 64'd1);
        chk("arb_rf_rdata", 64'(rdata[1]), 64'hA5A5A5A5);
        chk("arb_rf_bvalid", 64'(bvalid[1]), 64'd0);
        tick();
        chk("arb_wf_idle_valid", 64'(bif0.valid), 64'd0);
        chk("arb_wf_ar_waiting", 64'(arready[0]), 64'd0);
        tick();
        chk("arb_wf_second_write", 64'(bif0.write), 64'd0);
        chk("arb_wf_second_addr", 64'(bif0.address), 64'h0044);
        chk("arb_rf_second_write", 64'(bif1.write), 64'd1);
        chk("arb_rf_second_addr", 64'(bif1.address), 64'h0040);
        tick();
        chk("arb_wf_rvalid2", 64'(rvalid[0]), 64'd1);
        chk("arb_wf_rdata2", 64'(rdata[0]), 64'hA5A5A5A5);
        chk("arb_rf_bvalid2", 64'(bvalid[1]), 64'd1);
        tick();
        chk("arb_wf_done", 64'(rvalid[0]), 64'd0);

        // reset while the bus request is outstanding
        bus_ready = 1'b0;
        awvalid = 1'b1; awaddr = 16'h0050;
        wvalid = 1'b1; wdata = 32'h55555555; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("mrst_valid_before", 64'(bif0.valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(bif0.valid), 64'd0);
        chk("mrst_awready", 64'(awready[0]), 64'd1);
        chk("mrst_wready", 64'(wready[0]), 64'd1);
        chk("mrst_arready", 64'(arready[0]), 64'd1);
        chk("mrst_bvalid", 64'(bvalid[0]), 64'd0);
        bus_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mrst_no_b_%0d", i), 64'(bvalid[0]), 64'd0);
            chk($sformatf("mrst_no_valid_%0d", i), 64'(bif0.valid), 64'd0);
        end
        awvalid = 1'b1; awaddr = 16'h0060;
        wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hC;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("post_valid", 64'(bif0.valid), 64'd1);
        chk("post_addr", 64'(bif0.address), 64'h0060);
        chk("post_strobe", 64'(bif0.strobe), 64'hC);
        tick();
        chk("post_bvalid", 64'(bvalid[0]), 64'd1);
        chk("post_bresp", 64'(bresp[0]), 64'd0);
        tick();
        chk("post_bvalid_done", 64'(bvalid[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rggen_axi4lite_bridge.md
# rggen_axi4lite_bridge

Protocol front end of the register block. Terminates an AXI4-Lite slave port, serialises write and read transactions, and drives one request at a time onto the master side of `rggen_bus_if`, which feeds the register-side adapter. Bus responses (ready, status, read_data) are captured and returned on the AXI B/R channels. One transaction is in flight on the bus at a time.

## Interface
- ADDRESS_WIDTH, 16, byte address width on AXI and on `bus_if.address`
- BUS_WIDTH, 32, data width; 32 or 64
- WRITE_FIRST, 1, tie-break when write and read are both ready in IDLE: 1 = write wins, 0 = read wins
- Reset is `i_rst_n`, asynchronous, active-low; clock is `i_clk`.
- i_clk  input  1  clock
- i_rst_n  input  1  async active-low reset
- i_awvalid / o_awready  in/out  1  AW handshake
- i_awaddr  input  ADDRESS_WIDTH  write address
- i_wvalid / o_wready  in/out  1  W handshake
- i_wdata  input  BUS_WIDTH  write data
- i_wstrb  input  BUS_WIDTH/8  byte strobes
- o_bvalid / i_bready  out/in  1  B handshake
- o_bresp  output  2  write response
- i_arvalid / o_arready  in/out  1  AR handshake
- i_araddr  input  ADDRESS_WIDTH  read address
- o_rvalid / i_rready  out/in  1  R handshake
- o_rdata  output  BUS_WIDTH  read data
- o_rresp  output  2  read response
- bus_if  `rggen_bus_if.master`  -  request/response toward the register adapter

## Operation
- Three holding registers: AW (addr), W (data, strb), AR (addr). Each has a full flag. Ready = !full. Handshake sets full and captures the payload. AW and W are independent and may arrive in either order or in the same cycle.
- Write pending = AW full && W full. Read pending = AR full.
- FSM states: IDLE, BUS, RESP.
  - IDLE: if any request is pending, grant one by WRITE_FIRST, latch the grant, and go to BUS.
  - BUS: `bus_if.valid`=1. address, write, write_data and strobe come from the granted holding register(s) and are held stable. Reads drive write=0, write_data=0, strobe=all-ones. When `bus_if.ready`=1, capture status (2-bit, cast directly to resp: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and read_data (reads only). Clear the granted full flag(s) and go to RESP.
  - RESP: assert o_bvalid (write) or o_rvalid (read) with the captured resp/data. On the AXI handshake, go to IDLE.
- Holding registers freed on bus completion may accept the next AW/W/AR during RESP. That request is not issued until IDLE.
- AXI prot/ID are not carried; the AWPROT/ARPROT inputs are omitted.

## Timing
- Reset values: o_awready=o_wready=o_arready=1; o_bvalid=o_rvalid=0; o_bresp=o_rresp=00; o_rdata=0; bus_if.valid=0; FSM=IDLE; all full flags=0.
- AW+W handshaken at cycle T: IDLE sees pending at T+1, bus valid at T+2. If the bus is ready at T+2, o_bvalid is at T+3. If bready is 1 at T+3, the FSM is in IDLE at T+4.
- Bus wait states: valid and payload held unchanged until ready. There is no timeout.
- B/R backpressure: resp/data held stable until bready/rready.
- Write and read pending in the same IDLE cycle: the WRITE_FIRST side is issued; the other waits and issues in the next IDLE.
- Reset mid-transaction: immediate return to reset values. The in-flight request is dropped and no response is issued.

## Structure
- `rggen_rtl_pkg` supplies `rggen_status`. Add to the package: state enum `rggen_axi4lite_bridge_state` (IDLE/BUS/RESP) and the constant `RGGEN_AXI_RESP_WIDTH = 2`.
- Sub-module `rggen_request_holder #(WIDTH)`: valid/ready capture register with full flag, payload output, and clear input. Instantiated three times (AW, W, AR).

## Test plan
- Single write: awaddr=0x0010, wdata=0xDEADBEEF, wstrb=0xF in the same cycle; bus ready at first valid → bus address 0x0010, write=1, strobe=0xF; bvalid at T+3, bresp=00.
- W two cycles before AW, bus ready after 3 wait cycles → bus payload stable for 4 cycles; a single bus valid pulse train; bresp=00.
- Read with bus status SLAVE_ERROR, read_data=0x12345678 → rvalid, rresp=10, rdata=0x12345678; held 5 cycles under rready=0.
- AW+W and AR in the same cycle, WRITE_FIRST=1 → write issued first, read issued after the B handshake; repeat with WRITE_FIRST=0 → read first.
- Reset asserted during BUS with valid=1 → bus valid=0, all readies=1, no B response afterward; a new write completes normally.
